shift_normalizer: RTL



---
 rtl/shift_normalizer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/shift_normalizer.sv
// shift_normalizer: multi-cycle left-shift normalizer (leading-zero / redundant-sign count).
// A value loaded on start is shifted left one bit per cycle until its top bit is set
// (logical) or its top two bits differ (arithmetic). The normalized value, the shift
// count and a degenerate-operand flag are then presented for a one-cycle done pulse.
// Optional feature macro: SHIFT_NORMALIZER_DOUBLESTEP_EN -- when defined, a cycle may
// shift by two when that cannot overshoot normalization, giving bit-identical results
// in fewer cycles.
module shift_normalizer #(
    parameter  int DataLength = 4,
    localparam int CountWidth = $clog2(DataLength + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DataLength-1:0] numIn,
    output logic                  busy,
    output logic                  done,
    output logic [DataLength-1:0] result,
    output logic [CountWidth-1:0] shiftCount,
    output logic                  zeroFlag
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DataLength-1:0]   val_q, val_d;
    logic [CountWidth-1:0]   cnt_q, cnt_d;
    logic                    mode_q, mode_d;
    logic [DataLength-1:0]   result_q, result_d;
    logic [CountWidth-1:0]   shift_q, shift_d;
    logic                    zero_q, zero_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Normalized test for either mode.
    function automatic logic is_norm(input logic [DataLength-1:0] v, input logic m);
        return m ? (v[DataLength-1] ^ v[DataLength-2]) : v[DataLength-1];
    endfunction

    // Next-state, working-register and result computation.
    always_comb begin
        logic degen;
`ifdef SHIFT_NORMALIZER_DOUBLESTEP_EN
        int   max_shift;
`endif
        state_d  = state_q;
        val_d    = val_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        result_d = result_q;
        shift_d  = shift_q;
        zero_d   = zero_q;
        // Count only grows in SHIFT, so count==0 marks the first SHIFT cycle.
        degen    = (cnt_q == '0) &&
                   (mode_q ? ((val_q == '0) || (val_q == '1)) : (val_q == '0));
`ifdef SHIFT_NORMALIZER_DOUBLESTEP_EN
        max_shift = mode_q ? (DataLength - 2) : (DataLength - 1);
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    val_d   = numIn;
                    cnt_d   = '0;
                    mode_d  = mode;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (degen) begin
                    state_d  = DONE;
                    result_d = val_q;
                    shift_d  = mode_q ? CountWidth'(DataLength - 1) : CountWidth'(DataLength);
                    zero_d   = 1'b1;
                end else if (is_norm(val_q, mode_q)) begin
                    state_d  = DONE;
                    result_d = val_q;
                    shift_d  = cnt_q;
                    zero_d   = 1'b0;
                end else begin
`ifdef SHIFT_NORMALIZER_DOUBLESTEP_EN
                    // Double step only when one shift still would not normalize and
                    // the count stays within the mode's limit.
                    if (!is_norm(val_q << 1, mode_q) && (int'(cnt_q) + 2 <= max_shift)) begin
                        val_d = val_q << 2;
                        cnt_d = cnt_q + CountWidth'(2);
                    end else begin
                        val_d = val_q << 1;
                        cnt_d = cnt_q + CountWidth'(1);
                    end
`else
                    val_d = val_q << 1;
                    cnt_d = cnt_q + CountWidth'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            val_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            result_q <= '0;
            shift_q  <= '0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            shift_q  <= shift_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign shiftCount = shift_q;
    assign zeroFlag   = zero_q;

endmodule
